screen_scanner: RTL
===================

SCREEN_SCANNER -- requirements
Module: screen_scanner

Interface
REQ-001 The block SHALL expose these ports:
  clock     input   1   single clock; all state updates on rising edge
  reset_n   input   1   synchronous, active-low reset
  pixel_en  input   1   pixel-tick enable; at most one tick per clock
  scr_addr  output  13  word address into the 8K-word screen region
  scr_rd    output  1   one-clock read strobe qualifying scr_addr
  scr_data  input   16  screen word, valid exactly one clock after scr_rd
  pix       output  1   pixel value; 1 = black
  de        output  1   display-enable; high for visible pixels
  hsync     output  1   horizontal sync; active high
  vsync     output  1   vertical sync; active high
  frame_end output  1   one-clock pulse at the end of each frame

Function
REQ-002 The block SHALL hold a horizontal counter h (0..639) and a vertical counter v (0..279), advanced only on clocks with pixel_en=1.
REQ-003 h SHALL wrap from 639 to 0 and increment v; v SHALL wrap from 279 to 0 when h wraps.
REQ-004 The visible area SHALL be h<512 and v<256.
REQ-005 Horizontal sync SHALL cover h 528..591 (front porch 16, sync 64, back porch 48).
REQ-006 Vertical sync SHALL cover v 260..263 (front porch 4, sync 4, back porch 16).
REQ-007 On a tick with visible (h,v) and h[3:0]=0, the block SHALL assert scr_rd for that clock only, with scr_addr = v*32 + h/16.
REQ-008 scr_rd SHALL never assert outside the visible area: exactly 8192 strobes per frame, addresses 0..8191 in ascending order.
REQ-009 The block SHALL capture scr_data on the clock after scr_rd into a fetch register.
REQ-010 On the next pixel_en tick, the block SHALL load the fetch register into a 16-bit shift register.
REQ-011 Shift-register bit 0 SHALL be output first: column c uses bit c mod 16, LSB leftmost.
REQ-012 pix, de, hsync and vsync SHALL be registered and mutually aligned.
REQ-013 These outputs SHALL reflect counter position (h,v) exactly two pixel_en ticks later.
REQ-014 pix SHALL be 0 whenever de=0.
REQ-015 Outputs SHALL hold their values on clocks with pixel_en=0; sparse or irregular pixel_en SHALL NOT corrupt data.
REQ-016 frame_end SHALL pulse for one clock on the tick at which (h,v) wraps from (639,279) to (0,0).
REQ-017 A screen-word change takes effect from the next fetch of that word; no intra-word tearing within a 16-pixel group.

Reset
REQ-018 While reset_n=0 at a clock edge: h=0, v=0, shift and fetch registers 0; scr_rd, pix, de, hsync, vsync and frame_end all 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame; any read data still pending SHALL be discarded.
REQ-020 The first tick after reset release SHALL correspond to counter position (0,0).
REQ-021 The first visible pixel SHALL appear on the third pixel_en tick after reset release.
REQ-022 reset_n SHALL take priority over pixel_en.

Structure
REQ-023 A shared package SHALL hold the timing constants: H_ACTIVE=512, H_FP=16, H_SYNC=64, H_TOTAL=640, V_ACTIVE=256, V_FP=4, V_SYNC=4, V_TOTAL=280, WORDS_PER_ROW=32.
REQ-024 One sub-module, scan_timing, SHALL contain the h/v counters and the sync/visible decode; fetch and shift logic SHALL remain in screen_scanner.

Verification
REQ-025 Reset then pixel_en=1 continuously -> scr_rd first asserts at tick 0 with scr_addr=0; the first de=1 appears at tick 2; 8192 strobes occur per frame, the last with scr_addr=8191.
REQ-026 Word 0=16'h0001, other words 0 -> row 0: pix=1 only at column 0, all other pixels 0; word 16'h8000 at addr 33 -> pix=1 only at row 1, column 31.
REQ-027 Continuous ticks -> hsync high for 64 ticks per line starting at aligned h=528; vsync high for lines 260..263; frame_end once every 640*280=179200 ticks.
REQ-028 pixel_en asserted every 3rd clock with a random screen image -> pixel stream identical to the continuous-tick run; scr_rd timing tracks ticks.
REQ-029 reset_n pulsed low at (h=300,v=100) -> all outputs 0 during reset; after release, addressing restarts at scr_addr=0 and no stale pixel from the aborted word appears.

Source files
------------

// File: rtl/screen_scanner_pkg.sv
// -----------------------------------------------------------------------------
// screen_scanner_pkg
// Shared timing constants, counter types and helpers for the monochrome screen
// scanner. A 512x256 visible raster sits inside a 640x280 total frame. Each
// 16-bit screen word covers 16 horizontally adjacent pixels.
// -----------------------------------------------------------------------------
package screen_scanner_pkg;

    localparam int H_ACTIVE      = 512;
    localparam int H_FP          = 16;
    localparam int H_SYNC        = 64;
    localparam int H_BP          = 48;
    localparam int H_TOTAL       = 640;

    localparam int V_ACTIVE      = 256;
    localparam int V_FP          = 4;
    localparam int V_SYNC        = 4;
    localparam int V_BP          = 16;
    localparam int V_TOTAL       = 280;

    localparam int WORDS_PER_ROW = 32;
    localparam int WORD_BITS     = 16;
    localparam int ADDR_W        = 13;

    typedef logic [9:0]            hcount_t;
    typedef logic [8:0]            vcount_t;
    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [WORD_BITS-1:0]  word_t;

    // Per-position decode carried down the output pipeline.
    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
        logic word_start;   // visible and first pixel of a 16-pixel group
    } scan_flags_t;

    // Screen word holding pixel (h, v): row-major, WORDS_PER_ROW words per row.
    function automatic addr_t word_addr(input hcount_t h, input vcount_t v);
        return addr_t'(int'(v) * WORDS_PER_ROW + int'(h) / WORD_BITS);
    endfunction

endpackage

// File: rtl/screen_scanner_if.sv
// -----------------------------------------------------------------------------
// screen_scanner_if
// Read port into the 8K-word screen memory region.
//   scr_addr : word address, qualified by scr_rd
//   scr_rd   : one-clock read strobe
//   scr_data : read word, valid exactly one clock after scr_rd
// master = scanner side, slave = memory side.
// -----------------------------------------------------------------------------
interface screen_scanner_if;
    import screen_scanner_pkg::*;

    addr_t scr_addr;
    logic  scr_rd;
    word_t scr_data;

    modport master (output scr_addr, output scr_rd, input scr_data);
    modport slave  (input scr_addr, input scr_rd, output scr_data);

endinterface

// File: rtl/screen_scanner_scan_timing.sv
// -----------------------------------------------------------------------------
// scan_timing
// Horizontal/vertical raster counters plus visible-area and sync decode.
// Counters advance only on pixel ticks.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   pixel_en       : pixel tick
//   h, v           : current raster position
//   flags          : decode of (h, v): visible, hsync, vsync, word_start
//   last           : (h, v) is the final position of the frame
// Vertical geometry is parameterised (defaults are the production values) so a
// shorter frame can be elaborated; horizontal geometry is fixed by the package.
// -----------------------------------------------------------------------------
module scan_timing
    import screen_scanner_pkg::*;
#(
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FPORCH = V_FP,
    parameter int V_SLEN   = V_SYNC,
    parameter int V_TOT    = V_TOTAL
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pixel_en,
    output hcount_t     h,
    output vcount_t     v,
    output scan_flags_t flags,
    output logic        last
);

    localparam hcount_t H_LAST   = hcount_t'(H_TOTAL - 1);
    localparam hcount_t H_VIS    = hcount_t'(H_ACTIVE);
    localparam hcount_t HS_START = hcount_t'(H_ACTIVE + H_FP);
    localparam hcount_t HS_END   = hcount_t'(H_ACTIVE + H_FP + H_SYNC);

    localparam vcount_t V_LAST   = vcount_t'(V_TOT - 1);
    localparam vcount_t V_VIS    = vcount_t'(V_ACT);
    localparam vcount_t VS_START = vcount_t'(V_ACT + V_FPORCH);
    localparam vcount_t VS_END   = vcount_t'(V_ACT + V_FPORCH + V_SLEN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (pixel_en) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 9'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        flags            = '0;
        flags.visible    = (h < H_VIS) && (v < V_VIS);
        flags.hsync      = (h >= HS_START) && (h < HS_END);
        flags.vsync      = (v >= VS_START) && (v < VS_END);
        flags.word_start = flags.visible && (h[3:0] == 4'd0);
    end

    assign last = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/screen_scanner.sv
// -----------------------------------------------------------------------------
// screen_scanner
// Scans a 1-bit-per-pixel screen image out of memory and serialises it with
// registered display-enable and sync outputs.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset (wins over pixel_en)
//   pixel_en       : pixel tick, at most one per clock
//   scr            : screen read port (master)
//   pix            : pixel, 1 = black, forced 0 outside the visible area
//   de             : display enable
//   hsync, vsync   : active-high syncs
//   frame_end      : one-clock pulse on the tick that wraps (639,279)->(0,0)
// Pipeline: tick t issues the read for the word starting at position t; the
// word lands in the fetch register one clock later; registered outputs for
// position t update on tick t+2, when the fetched word is loaded into the
// shift register and its bit 0 goes straight to pix.
// -----------------------------------------------------------------------------
module screen_scanner
    import screen_scanner_pkg::*;
#(
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FPORCH = V_FP,
    parameter int V_SLEN   = V_SYNC,
    parameter int V_TOT    = V_TOTAL
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pixel_en,
    screen_scanner_if.master  scr,
    output logic              pix,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_end
);

    hcount_t     h;
    vcount_t     v;
    scan_flags_t flags;
    logic        last;

    scan_flags_t s1;        // decode of the position one tick back
    scan_flags_t s2;        // decode of the position two ticks back
    logic        rd_q;      // read issued last clock, data on the bus now
    word_t       fetch;
    word_t       shift;

    scan_timing #(
        .V_ACT    (V_ACT),
        .V_FPORCH (V_FPORCH),
        .V_SLEN   (V_SLEN),
        .V_TOT    (V_TOT)
    ) u_timing (
        .clock    (clock),
        .reset_n  (reset_n),
        .pixel_en (pixel_en),
        .h        (h),
        .v        (v),
        .flags    (flags),
        .last     (last)
    );

    // Strobe and frame marker are tied to the tick itself, so they are
    // combinational; reset_n gates them so they are low during reset.
    assign scr.scr_rd   = reset_n & pixel_en & flags.word_start;
    assign scr.scr_addr = word_addr(h, v);
    assign frame_end    = reset_n & pixel_en & last;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1    <= '0;
            s2    <= '0;
            rd_q  <= 1'b0;     // drops any read still in flight
            fetch <= '0;
            shift <= '0;
            pix   <= 1'b0;
            de    <= 1'b0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else begin
            // Capture runs on every clock, independent of pixel ticks, so the
            // word is held safely however sparse the ticks are.
            rd_q <= scr.scr_rd;
            if (rd_q) begin
                fetch <= scr.scr_data;
            end

            if (pixel_en) begin
                s1    <= flags;
                s2    <= s1;
                de    <= s2.visible;
                hsync <= s2.hsync;
                vsync <= s2.vsync;
                if (s2.word_start) begin
                    // First column of a group: take bit 0 now, keep the rest.
                    pix   <= fetch[0];
                    shift <= fetch >> 1;
                end else begin
                    pix   <= s2.visible & shift[0];
                    shift <= shift >> 1;
                end
            end
        end
    end

endmodule
